// File: rtl/term_pkg.sv
// Shared definitions for the character-cell terminal: control codes and sweep states.
package term_pkg;

    localparam logic [7:0] CC_BS  = 8'h08;
    localparam logic [7:0] CC_TAB = 8'h09;
    localparam logic [7:0] CC_LF  = 8'h0A;
    localparam logic [7:0] CC_FF  = 8'h0C;
    localparam logic [7:0] CC_CR  = 8'h0D;

    typedef enum logic [1:0] {
        IDLE,
        CLR_ROW,
        CLR_ALL
    } term_state_t;

endpackage

// File: rtl/term_ram.sv
// Simple dual-port character store: one synchronous write port, one registered read port.
module term_ram #(
    parameter int DEPTH = 2400,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Separate read process keeps old data on a same-address collision.
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/term_buffer.sv
// Character-cell terminal core: byte stream in, scrolling COLS x ROWS framebuffer out,
// with a blinking cursor overlaid on the read path.
module term_buffer
    import term_pkg::*;
#(
    parameter int         COLS        = 80,
    parameter int         ROWS        = 30,
    parameter logic [7:0] BLANK       = 8'h20,
    parameter logic [7:0] CURSOR_CHAR = 8'h5F,
    parameter int         BLINK_BITS  = 23,
    parameter int         TAB_W       = 8,
    localparam int        XW          = $clog2(COLS),
    localparam int        YW          = $clog2(ROWS),
    localparam int        DEPTH       = COLS * ROWS,
    localparam int        AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] rd_col,
    input  logic [YW-1:0] rd_row,
    output logic [7:0]    rd_data,
    output logic [XW-1:0] cursor_x,
    output logic [YW-1:0] cursor_y,
    output logic          busy
);

    function automatic logic [YW-1:0] phys_row(input logic [YW-1:0] lrow, input logic [YW-1:0] t);
        logic [YW:0] sum;
        sum = {1'b0, lrow} + {1'b0, t};
        if (sum >= (YW+1)'(ROWS)) sum = sum - (YW+1)'(ROWS);
        return sum[YW-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] prow, input logic [XW-1:0] col);
        return AW'(prow) * AW'(COLS) + AW'(col);
    endfunction

    function automatic logic [XW-1:0] tab_stop(input logic [XW-1:0] col);
        logic [XW:0] nxt;
        nxt = {1'b0, col & ~XW'(TAB_W - 1)} + (XW+1)'(TAB_W);
        if (nxt > (XW+1)'(COLS - 1)) nxt = (XW+1)'(COLS - 1);
        return nxt[XW-1:0];
    endfunction

    term_state_t state, state_nxt;
    logic [XW-1:0] x, x_nxt;
    logic [YW-1:0] y, y_nxt;
    logic [YW-1:0] top, top_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic          blink_on;
    logic          newline;
    logic          printable;

    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;

    logic [7:0]    ram_q_p1;
    logic          hit_p1;
    logic          vld_p1;

    assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign in_ready  = (state == IDLE);
    assign busy      = !in_ready;
    assign cursor_x  = x;
    assign cursor_y  = y;

    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        top_nxt   = top;
        cnt_nxt   = cnt;
        newline   = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    if (printable) begin
                        if (x < XW'(COLS - 1)) x_nxt = x + 1'b1;
                        else begin
                            x_nxt   = '0;
                            newline = 1'b1;
                        end
                    end else begin
                        case (in_data)
                            CC_CR:  x_nxt = '0;
                            CC_LF:  newline = 1'b1;
                            CC_BS:  if (x != '0) x_nxt = x - 1'b1;
                            CC_TAB: x_nxt = tab_stop(x);
                            CC_FF: begin
                                state_nxt = CLR_ALL;
                                cnt_nxt   = '0;
                            end
                            default: ;
                        endcase
                    end
                    // Newline on the last row scrolls: the old top row becomes the new bottom.
                    if (newline) begin
                        if (y < YW'(ROWS - 1)) y_nxt = y + 1'b1;
                        else begin
                            top_nxt   = (top == YW'(ROWS - 1)) ? '0 : top + 1'b1;
                            state_nxt = CLR_ROW;
                            cnt_nxt   = '0;
                        end
                    end
                end
            end
            CLR_ROW: begin
                if (cnt == AW'(COLS - 1)) state_nxt = IDLE;
                else cnt_nxt = cnt + 1'b1;
            end
            CLR_ALL: begin
                if (cnt == AW'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                    top_nxt   = '0;
                    x_nxt     = '0;
                    y_nxt     = '0;
                end else cnt_nxt = cnt + 1'b1;
            end
            default: begin
                state_nxt = CLR_ALL;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        we    = 1'b0;
        waddr = cell_addr(phys_row(y, top), x);
        wdata = BLANK;
        case (state)
            IDLE: begin
                if (in_valid && printable) begin
                    we    = 1'b1;
                    wdata = in_data;
                end
            end
            CLR_ROW: begin
                we    = 1'b1;
                waddr = cell_addr(phys_row(y, top), XW'(cnt));
            end
            CLR_ALL: begin
                we    = 1'b1;
                waddr = cnt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLR_ALL;
            cnt       <= '0;
            top       <= '0;
            x         <= '0;
            y         <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            top       <= top_nxt;
            x         <= x_nxt;
            y         <= y_nxt;
            blink_cnt <= blink_cnt + 1'b1;
            if (&blink_cnt) blink_on <= ~blink_on;
            vld_p1    <= 1'b1;
        end
    end

    // Read stage p0 -> p1: memory read and cursor hit registered together.
    always_ff @(posedge clk) begin
        hit_p1 <= blink_on && (rd_col == x) && (rd_row == y);
    end

    term_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (cell_addr(phys_row(rd_row, top), rd_col)),
        .rdata (ram_q_p1)
    );

    assign rd_data = !vld_p1 ? 8'h00 : (hit_p1 ? CURSOR_CHAR : ram_q_p1);

endmodule

// File: doc/term_buffer.md
# term_buffer

Parametrised character-cell terminal core: accepts a byte stream over a valid/ready handshake, interprets printable and control codes, and maintains a COLS×ROWS text framebuffer with hardware scrolling via a circular top-row offset. A registered read port serves the video/font pipeline, with a blinking cursor overlaid on the read path rather than written into memory. Sits between `uart_rx`, or any byte source, and `font_rom`/`hdmi_video`, replacing ad-hoc framebuffer logic in top-level designs.

## Interface
- COLS, 80, columns per row
- ROWS, 30, rows per screen
- BLANK, 8'h20, fill character for clears
- CURSOR_CHAR, 8'h5F, glyph shown at cursor during blink-on phase
- BLINK_BITS, 23, blink half-period is 2^BLINK_BITS cycles
- TAB_W, 8, tab stop spacing (power of 2)
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- in_data  in  8  input byte
- in_valid  in  1  byte available
- in_ready  out  1  core can accept a byte this cycle
- rd_col  in  clog2(COLS)  video read column
- rd_row  in  clog2(ROWS)  video read row (logical, 0 = top of screen)
- rd_data  out  8  character at (rd_col, rd_row), 1-cycle latency
- cursor_x  out  clog2(COLS)  cursor column
- cursor_y  out  clog2(ROWS)  cursor row (logical)
- busy  out  1  clear/scroll in progress

## Operation
- Byte accepted when in_valid && in_ready.
- States: IDLE, CLR_ROW, CLR_ALL. in_ready = (state == IDLE); busy = !in_ready.
- Physical row = (logical row + top) mod ROWS. Address = phys_row*COLS + col.
- Codes, all handled in IDLE:
  - 0x20–0x7E: write at the cursor. If x < COLS-1, then x+1. Otherwise x=0 and do a newline.
  - 0x0D (CR): x=0.
  - 0x0A (LF): newline.
  - 0x08 (BS): x-1 if x>0, else no-op. Does not erase.
  - 0x09 (TAB): x = min((x & ~(TAB_W-1)) + TAB_W, COLS-1).
  - 0x0C (FF): enter CLR_ALL, then home.
  - All other codes are ignored, with no state change.
- Newline:
  - If y < ROWS-1, then y+1.
  - Otherwise y stays at ROWS-1, top = (top+1) mod ROWS, and the core enters CLR_ROW to clear the new bottom physical row.
- CLR_ROW: column counter 0..COLS-1 writes BLANK, then returns to IDLE.
- CLR_ALL: linear address counter 0..COLS*ROWS-1 writes BLANK. On completion: top=0, x=y=0, return to IDLE.
- Reset: top=0, cursor (0,0), blink phase 0, blink counter 0, state=CLR_ALL. Memory itself is not reset; it is cleared by the CLR_ALL sweep.
- Cursor overlay: if the blink phase is 1 and the registered read coordinates equal the cursor, rd_data = CURSOR_CHAR.
- Blink counter runs free. The phase toggles when the counter wraps.

## Timing
- Printable and non-scrolling codes: in_ready stays high, so throughput is 1 byte/cycle.
- The cursor outputs update the cycle after acceptance.
- A scroll-causing byte holds in_ready low for exactly COLS cycles after acceptance. FF holds it low for COLS*ROWS cycles.
- After reset deasserts, in_ready rises COLS*ROWS cycles later.
- rd_data is registered with 1-cycle latency. It uses the top value and cursor position current at the sample edge.
- A same-address write and read in the same cycle returns the old data (read-before-write).
- Reset asserted mid-CLR_ROW or mid-CLR_ALL aborts the sweep and restarts CLR_ALL from address 0. rd_data reset value is 8'h00.
- in_valid while in_ready is low is ignored, and the byte must be held by the source.

## Structure
- Shared package `term_pkg` holds:
  - control-code constants: CC_CR, CC_LF, CC_BS, CC_TAB, CC_FF
  - state enum term_state_t {IDLE, CLR_ROW, CLR_ALL}
- Sub-module `term_ram`: simple dual-port RAM, depth COLS*ROWS, 8 bits wide, one synchronous write port, one registered read port. It must infer block RAM.
- Address multiply uses constant COLS, so it resolves to shift/add.

## Test plan
- Reset for 1 cycle, then release:
  - in_ready stays low for 2400 cycles, then rises.
  - Every read returns 0x20 (BLINK_BITS=4 in the bench, cursor cell masked).
  - Cursor is (0,0).
- Send "AB\r\n":
  - (0,0)=0x41 and (1,0)=0x42.
  - Cursor is (0,1).
  - in_ready is never low.
- Fill 30 lines with "Ln" + CR LF:
  - On the 30th LF, in_ready is low for exactly 80 cycles.
  - Logical row 0 then reads the former row 1's content.
  - Row 29 is all 0x20, and the cursor is (0,29).
- Cursor-movement codes:
  - BS at x=0 is a no-op.
  - TAB from x=3 gives x=8.
  - TAB from x=77 gives x=79.
  - Printable at x=79 writes col 79, and the cursor becomes (0,y+1).
- Blink and ignored codes:
  - With BLINK_BITS=4, a read at the cursor alternates 0x5F/0x20 every 16 cycles.
  - Bytes 0x01 and 0x7F produce no memory or cursor change.
- Reset mid-CLR_ROW at cycle 40 of 80:
  - Full 2400-cycle clear follows, with top=0 and cursor (0,0).
  - All cells read 0x20.
  - An FF mid-screen gives the same result.
